// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - memory-stage front end: sw data bypass, FIFO store buffer with load forwarding
// Stores retire into the buffer without stalling; a req/ack FSM drains them or services load misses.
module mem_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       XM_instruction,
  input  logic [31:0]       MW_instruction,
  input  logic [ADDR_W-1:0] XM_addr,
  input  logic [DATA_W-1:0] XM_B,
  input  logic [DATA_W-1:0] MW_D,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic              stall,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_LOAD} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              xm_sw, xm_lw, mw_lw, rd_match;
  logic [DATA_W-1:0] store_data;
  logic              pop, accept, push;
  logic              hit, load_miss;
  logic [DATA_W-1:0] hit_data;
  logic [PTR_W-1:0]  slot;
  logic              unused_bits;

  assign xm_sw    = XM_instruction[31:27] == OP_SW;
  assign xm_lw    = XM_instruction[31:27] == OP_LW;
  assign mw_lw    = MW_instruction[31:27] == OP_LW;
  assign rd_match = XM_instruction[26:22] == MW_instruction[26:22];
  assign unused_bits = ^{XM_instruction[21:0], MW_instruction[21:0]};

  assign store_data = (mw_lw && rd_match) ? MW_D : XM_B;

  // A completing drain frees its slot in the same cycle, so a full buffer can still take a store.
  assign pop    = (state_q == ST_DRAIN) && mem_ack;
  assign accept = (count_q < CNT_W'(DEPTH)) || pop;
  assign push   = xm_sw && accept;

  // Walk oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[slot] == XM_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[slot];
      end
    end
  end

  assign load_miss = xm_lw && !hit;

  always_comb begin
    ld_data = '0;
    if (xm_lw) begin
      ld_data = hit ? hit_data : mem_rdata;
    end
  end

  assign stall = (xm_sw && !accept) ||
                 (load_miss && !((state_q == ST_LOAD) && mem_ack));

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      addr_d[tail_q] = XM_addr;
      data_d[tail_q] = store_data;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Request fields are loaded only on leaving IDLE and then held, so a request never changes in flight.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (load_miss) begin
          state_d     = ST_LOAD;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = XM_addr;
          mem_wdata_d = '0;
        end else if (count_q != '0) begin
          state_d     = ST_DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = data_q[head_q];
        end
      end
      ST_DRAIN, ST_LOAD: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign full      = count_q == CNT_W'(DEPTH);
  assign empty     = count_q == '0;

endmodule

// File: tb/tb_mem_store_buffer.sv
// tb/tb_mem_store_buffer.sv - scoreboard bench for mem_store_buffer
// Loads are expected to return the latest value stored in program order; drains must follow store order.
module tb_mem_store_buffer;

  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_NOP = 5'b00001;

  logic        clock;
  logic        reset;
  logic [31:0] XM_instruction, MW_instruction;
  logic [11:0] XM_addr;
  logic [31:0] XM_B, MW_D;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data;
  logic        stall;
  logic [2:0]  count;
  logic        full, empty;

  logic        auto_ack, auto_ack_r, man_ack;
  logic [31:0] mem_model [4096];
  logic [31:0] ref_mem [4096];
  logic [43:0] wq [$];
  logic [31:0] lq [$];
  int          total, bad;

  mem_store_buffer dut (
    .clock(clock), .reset(reset),
    .XM_instruction(XM_instruction), .MW_instruction(MW_instruction),
    .XM_addr(XM_addr), .XM_B(XM_B), .MW_D(MW_D),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_data(ld_data), .stall(stall), .count(count), .full(full), .empty(empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_ack   = auto_ack ? auto_ack_r : man_ack;
  assign mem_rdata = (mem_req && !mem_we) ? mem_model[mem_addr] : 32'h0;

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return 32'h1234 + (32'(a) - 32'h40) * 32'h9E37;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Memory responder: commits writes at the ack edge, random ack latency in auto mode.
  initial begin
    int wl;
    wl = 0;
    auto_ack_r = 1'b0;
    for (int i = 0; i < 4096; i++) mem_model[i] = init_val(12'(i));
    forever begin
      @(posedge clock);
      if (reset && mem_req && mem_ack && mem_we) mem_model[mem_addr] = mem_wdata;
      #1;
      auto_ack_r = 1'b0;
      if (auto_ack && mem_req) begin
        if (wl == 0) begin
          auto_ack_r = 1'b1;
          wl = $urandom_range(0, 3);
        end else begin
          wl--;
        end
      end
    end
  end

  // Monitor: request stability, drain order, load results, occupancy.
  initial begin
    logic        pv_req, pv_ack, pv_we;
    logic [11:0] pv_addr;
    logic [31:0] pv_wdata;
    logic [43:0] we_exp;
    logic [31:0] le_exp;
    logic [4:0]  op;
    int          occ;
    pv_req = 1'b0; pv_ack = 1'b0; pv_we = 1'b0; pv_addr = '0; pv_wdata = '0; occ = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        pv_req = 1'b0;
        occ = 0;
      end else begin
        if (pv_req && !pv_ack)
          check("req_hold", {19'h0, mem_req, mem_we, mem_addr, mem_wdata},
                {19'h0, 1'b1, pv_we, pv_addr, pv_wdata});
        pv_req = mem_req; pv_ack = mem_ack; pv_we = mem_we;
        pv_addr = mem_addr; pv_wdata = mem_wdata;
        check("count", 64'(count), 64'(occ));
        op = XM_instruction[31:27];
        if (mem_req && mem_ack && mem_we) begin
          occ--;
          if (wq.size() == 0) begin
            check("drain_unexpected", 64'({mem_addr, mem_wdata}), 64'h0);
          end else begin
            we_exp = wq.pop_front();
            check("drain", 64'({mem_addr, mem_wdata}), 64'(we_exp));
          end
        end
        if (op == OP_SW && !stall) occ++;
        if (op == OP_LW && !stall) begin
          if (lq.size() == 0) begin
            check("load_unexpected", 64'(ld_data), 64'h0);
          end else begin
            le_exp = lq.pop_front();
            check("load", 64'(ld_data), 64'(le_exp));
          end
        end else if (op != OP_SW && op != OP_LW) begin
          check("nop_stall", 64'(stall), 64'h0);
          check("nop_ld", 64'(ld_data), 64'h0);
        end
      end
    end
  end

  task automatic present(input logic [4:0] xop, input logic [4:0] xrd, input logic [11:0] a,
                         input logic [31:0] b, input logic [4:0] mop, input logic [4:0] mrd,
                         input logic [31:0] d);
    logic [31:0] sd;
    XM_instruction = {xop, xrd, 22'($urandom)};
    MW_instruction = {mop, mrd, 22'($urandom)};
    XM_addr = a;
    XM_B = b;
    MW_D = d;
    if (xop == OP_SW) begin
      sd = (mop == OP_LW && mrd == xrd) ? d : b;
      wq.push_back({a, sd});
      ref_mem[a] = sd;
    end else if (xop == OP_LW) begin
      lq.push_back(ref_mem[a]);
    end
  endtask

  task automatic nop();
    present(OP_NOP, 5'd0, 12'h0, 32'h0, OP_NOP, 5'd0, 32'h0);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clock);
    while (stall && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (stall) check("accept_timeout", 64'(stall), 64'h0);
    @(posedge clock); #1;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clock);
    while (!(empty && !mem_req) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!(empty && !mem_req)) check("drain_timeout", {62'h0, empty, mem_req}, 64'h2);
    @(posedge clock); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    reset = 1'b0; auto_ack = 1'b0; man_ack = 1'b0;
    XM_instruction = '0; MW_instruction = '0; XM_addr = '0; XM_B = '0; MW_D = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_count", 64'(count), 64'h0);
    check("rst_empty", 64'(empty), 64'h1);
    check("rst_full", 64'(full), 64'h0);
    check("rst_req", 64'(mem_req), 64'h0);
    check("rst_we", 64'(mem_we), 64'h0);
    check("rst_addr", 64'(mem_addr), 64'h0);
    check("rst_wdata", 64'(mem_wdata), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_ld", 64'(ld_data), 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Fill with no acks, then a fifth store rides on the head's drain ack.
    for (int i = 0; i < 4; i++) begin
      present(OP_SW, 5'd1, 12'h10 + 12'(i), 32'hA000 + 32'(i), OP_NOP, 5'd0, 32'h0);
      wait_accept();
    end
    present(OP_SW, 5'd1, 12'h14, 32'hA004, OP_NOP, 5'd0, 32'h0);
    @(negedge clock);
    check("full_count", 64'(count), 64'h4);
    check("full_flag", 64'(full), 64'h1);
    check("full_stall", 64'(stall), 64'h1);
    check("full_head", {51'h0, mem_req, mem_we, mem_addr}, {51'h0, 1'b1, 1'b1, 12'h10});
    @(posedge clock); #1;
    man_ack = 1'b1;
    @(negedge clock);
    check("full_push_on_pop", 64'(stall), 64'h0);
    @(posedge clock); #1;
    man_ack = 1'b0;
    nop();
    @(negedge clock);
    check("full_count_after", 64'(count), 64'h4);
    @(posedge clock); #1;
    auto_ack = 1'b1;
    wait_empty();

    // Store-data bypass from an MW lw with matching and non-matching rd.
    present(OP_SW, 5'd5, 12'h20, 32'h1111, OP_LW, 5'd5, 32'hDEAD);
    wait_accept();
    present(OP_SW, 5'd5, 12'h21, 32'h1111, OP_LW, 5'd6, 32'hDEAD);
    wait_accept();
    nop();
    wait_empty();

    // Youngest-entry forwarding while the first store sits in a drain.
    auto_ack = 1'b0;
    present(OP_SW, 5'd2, 12'h30, 32'hA, OP_NOP, 5'd0, 32'h0);
    wait_accept();
    present(OP_SW, 5'd2, 12'h30, 32'hB, OP_NOP, 5'd0, 32'h0);
    wait_accept();
    present(OP_LW, 5'd3, 12'h30, 32'h0, OP_NOP, 5'd0, 32'h0);
    @(negedge clock);
    check("hit_stall", 64'(stall), 64'h0);
    check("hit_data", 64'(ld_data), 64'hB);
    check("hit_no_read", {62'h0, mem_req, mem_we}, 64'h3);
    @(posedge clock); #1;
    nop();
    auto_ack = 1'b1;
    wait_empty();

    // Load miss on an empty buffer, ack on the third request cycle.
    auto_ack = 1'b0;
    present(OP_LW, 5'd4, 12'h40, 32'h0, OP_NOP, 5'd0, 32'h0);
    @(negedge clock);
    check("miss_c0_stall", 64'(stall), 64'h1);
    check("miss_c0_req", 64'(mem_req), 64'h0);
    @(posedge clock); #1;
    @(negedge clock);
    check("miss_c1_stall", 64'(stall), 64'h1);
    check("miss_c1_req", {51'h0, mem_req, mem_we, mem_addr}, {51'h0, 1'b1, 1'b0, 12'h40});
    @(posedge clock); #1;
    @(negedge clock);
    check("miss_c2_stall", 64'(stall), 64'h1);
    @(posedge clock); #1;
    man_ack = 1'b1;
    @(negedge clock);
    check("miss_ack_stall", 64'(stall), 64'h0);
    check("miss_ack_data", 64'(ld_data), 64'h1234);
    @(posedge clock); #1;
    man_ack = 1'b0;
    nop();

    // Load miss during a drain waits, then beats the remaining store.
    present(OP_SW, 5'd1, 12'h50, 32'h5050, OP_NOP, 5'd0, 32'h0);
    wait_accept();
    present(OP_SW, 5'd1, 12'h58, 32'h5858, OP_NOP, 5'd0, 32'h0);
    wait_accept();
    present(OP_LW, 5'd1, 12'h60, 32'h0, OP_NOP, 5'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("dl_stall", 64'(stall), 64'h1);
      check("dl_drain_req", {51'h0, mem_req, mem_we, mem_addr}, {51'h0, 1'b1, 1'b1, 12'h50});
      @(posedge clock); #1;
    end
    man_ack = 1'b1;
    @(negedge clock);
    check("dl_ack_stall", 64'(stall), 64'h1);
    @(posedge clock); #1;
    man_ack = 1'b0;
    @(negedge clock);
    check("dl_gap_req", 64'(mem_req), 64'h0);
    @(posedge clock); #1;
    @(negedge clock);
    check("dl_read_req", {51'h0, mem_req, mem_we, mem_addr}, {51'h0, 1'b1, 1'b0, 12'h60});
    check("dl_read_count", 64'(count), 64'h1);
    @(posedge clock); #1;
    man_ack = 1'b1;
    @(negedge clock);
    check("dl_read_stall", 64'(stall), 64'h0);
    @(posedge clock); #1;
    man_ack = 1'b0;
    nop();
    auto_ack = 1'b1;
    wait_empty();

    // Random mix against the program-order memory model.
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [4:0] xop;
      r = $urandom_range(0, 99);
      xop = (r < 40) ? OP_SW : (r < 75) ? OP_LW : ((r % 2) ? 5'b00000 : 5'b10001);
      present(xop, 5'($urandom_range(0, 3)), 12'h80 + 12'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 1) != 0) ? OP_LW : OP_NOP, 5'($urandom_range(0, 3)), $urandom);
      wait_accept();
    end
    nop();
    wait_empty();
    check("wq_left", 64'(wq.size()), 64'h0);
    check("lq_left", 64'(lq.size()), 64'h0);

    // Reset with stores queued and a drain in flight.
    auto_ack = 1'b0;
    present(OP_SW, 5'd1, 12'h70, 32'h7070, OP_NOP, 5'd0, 32'h0);
    wait_accept();
    present(OP_SW, 5'd1, 12'h71, 32'h7171, OP_NOP, 5'd0, 32'h0);
    wait_accept();
    nop();
    @(negedge clock);
    check("pre_rst_req", {62'h0, mem_req, full}, 64'h2);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req", 64'(mem_req), 64'h0);
    check("mid_rst_count", 64'(count), 64'h0);
    check("mid_rst_empty", 64'(empty), 64'h1);
    wq.delete();
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("post_rst_idle", {62'h0, mem_req, empty}, 64'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
